// File: rtl/modexp_pkg.sv
// Shared types and defaults for the modular exponentiation block.
package modexp_pkg;

  localparam int DW_DEFAULT = 256;

  typedef enum logic [2:0] {
    IDLE,
    PRE_M,
    PRE_X,
    SQUARE,
    MULT,
    POST,
    DONE
  } state_t;

endpackage

// File: rtl/modexp_if.sv
// Job request / result handshake bundle for modexp.
interface modexp_if import modexp_pkg::*; #(
  parameter int DATAWIDTH = DW_DEFAULT
) ();

  logic                 i_valid;
  logic                 i_ready;
  logic [DATAWIDTH-1:0] i_M;
  logic [DATAWIDTH-1:0] i_E;
  logic [DATAWIDTH-1:0] i_N;
  logic [DATAWIDTH-1:0] i_R2;
  logic                 o_valid;
  logic                 o_ready;
  logic [DATAWIDTH-1:0] o_C;

  modport slave (
    input  i_valid, i_M, i_E, i_N, i_R2, o_ready,
    output i_ready, o_valid, o_C
  );

  modport master (
    output i_valid, i_M, i_E, i_N, i_R2, o_ready,
    input  i_ready, o_valid, o_C
  );

endinterface

// File: rtl/modexp_monpro.sv
// Bit-serial radix-2 Montgomery product: o_U = A * B * 2^-DATAWIDTH mod N.
// One bit of A per cycle, single final conditional subtraction; needs B < N.
module modexp_monpro import modexp_pkg::*; #(
  parameter int DATAWIDTH = DW_DEFAULT
) (
  input  logic                 clk,
  input  logic                 rstn,
  input  logic                 i_start,
  input  logic [DATAWIDTH-1:0] i_A,
  input  logic [DATAWIDTH-1:0] i_B,
  input  logic [DATAWIDTH-1:0] i_N,
  output logic                 o_ready,
  output logic                 o_valid,
  output logic [DATAWIDTH-1:0] o_U
);

  localparam int CW = $clog2(DATAWIDTH);
  localparam logic [CW-1:0] LAST = CW'(DATAWIDTH - 1);

  logic                 r_busy;
  logic                 r_valid;
  logic [CW-1:0]        r_cnt;
  logic [DATAWIDTH-1:0] r_a;
  logic [DATAWIDTH-1:0] r_b;
  logic [DATAWIDTH-1:0] r_n;
  logic [DATAWIDTH-1:0] r_U;
  // Partial result stays below 2N; the add of B and N needs two guard bits.
  logic [DATAWIDTH+1:0] r_u;
  logic [DATAWIDTH+1:0] w_sum;
  logic [DATAWIDTH+1:0] w_sum_n;
  logic [DATAWIDTH+1:0] w_u_shift;
  logic [DATAWIDTH-1:0] w_sub;
  logic [DATAWIDTH-1:0] w_final;

  // One Montgomery iteration plus the final reduction of its result.
  always_comb begin
    w_sum     = r_u + (r_a[0] ? {2'b00, r_b} : '0);
    w_sum_n   = w_sum + (w_sum[0] ? {2'b00, r_n} : '0);
    w_u_shift = w_sum_n >> 1;
    w_sub     = w_u_shift[DATAWIDTH-1:0] - r_n;
    w_final   = (w_u_shift >= {2'b00, r_n}) ? w_sub : w_u_shift[DATAWIDTH-1:0];
  end

  // Operand capture, iteration counter and one-cycle result strobe.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_busy  <= 1'b0;
      r_valid <= 1'b0;
      r_cnt   <= '0;
      r_a     <= '0;
      r_b     <= '0;
      r_n     <= '0;
      r_u     <= '0;
      r_U     <= '0;
    end else begin
      r_valid <= 1'b0;
      if (!r_busy) begin
        if (i_start) begin
          r_a    <= i_A;
          r_b    <= i_B;
          r_n    <= i_N;
          r_u    <= '0;
          r_cnt  <= '0;
          r_busy <= 1'b1;
        end
      end else begin
        r_a   <= r_a >> 1;
        r_u   <= w_u_shift;
        r_cnt <= r_cnt + CW'(1);
        if (r_cnt == LAST) begin
          r_busy  <= 1'b0;
          r_valid <= 1'b1;
          r_U     <= w_final;
        end
      end
    end
  end

  assign o_ready = !r_busy;
  assign o_valid = r_valid;
  assign o_U     = r_U;

endmodule

// File: rtl/modexp.sv
// Modular exponentiation C = M^E mod N by left-to-right square-and-multiply
// in the Montgomery domain, time-sharing a single Montgomery multiplier.
module modexp import modexp_pkg::*; #(
  parameter int DATAWIDTH = DW_DEFAULT
) (
  input  logic     clk,
  input  logic     rstn,
  modexp_if.slave  bus
);

  localparam int KW = $clog2(DATAWIDTH);
  localparam logic [KW-1:0]        K_MSB = KW'(DATAWIDTH - 1);
  localparam logic [DATAWIDTH-1:0] ONE   = DATAWIDTH'(1);

  state_t               r_state, w_state_next;
  logic                 r_busy, w_busy_next;
  logic [KW-1:0]        r_k, w_k_next;
  logic [DATAWIDTH-1:0] r_m, r_e, r_n, r_r2;
  logic [DATAWIDTH-1:0] r_x, w_x_next;
  logic [DATAWIDTH-1:0] r_mbar, w_mbar_next;
  logic [DATAWIDTH-1:0] r_c, w_c_next;
  logic                 w_accept, w_op_state;
  logic                 w_mp_start, w_mp_ready, w_mp_valid;
  logic [DATAWIDTH-1:0] w_mp_a, w_mp_b, w_mp_u;

  assign w_accept   = (r_state == IDLE) && bus.i_valid;
  assign w_op_state = (r_state != IDLE) && (r_state != DONE);

  // Multiplier operand select by phase of the exponentiation.
  always_comb begin
    w_mp_a = r_x;
    w_mp_b = r_x;
    case (r_state)
      PRE_M:   begin w_mp_a = r_m;    w_mp_b = r_r2; end
      PRE_X:   begin w_mp_a = ONE;    w_mp_b = r_r2; end
      MULT:    begin w_mp_a = r_mbar; w_mp_b = r_x;  end
      POST:    begin w_mp_a = r_x;    w_mp_b = ONE;  end
      default: ;
    endcase
  end

  // Next state, single start pulse per phase, capture of each product.
  always_comb begin
    w_state_next = r_state;
    w_busy_next  = r_busy;
    w_k_next     = r_k;
    w_x_next     = r_x;
    w_mbar_next  = r_mbar;
    w_c_next     = r_c;
    w_mp_start   = 1'b0;
    if (r_state == IDLE) begin
      if (bus.i_valid) w_state_next = PRE_M;
    end else if (r_state == DONE) begin
      if (bus.o_ready) w_state_next = IDLE;
    end else if (w_op_state) begin
      if (!r_busy) begin
        if (w_mp_ready) begin
          w_mp_start  = 1'b1;
          w_busy_next = 1'b1;
        end
      end else if (w_mp_valid) begin
        w_busy_next = 1'b0;
        case (r_state)
          PRE_M: begin
            w_mbar_next  = w_mp_u;
            w_state_next = PRE_X;
          end
          PRE_X: begin
            w_x_next     = w_mp_u;
            w_k_next     = K_MSB;
            w_state_next = SQUARE;
          end
          SQUARE, MULT: begin
            w_x_next = w_mp_u;
            if ((r_state == SQUARE) && r_e[r_k]) begin
              w_state_next = MULT;
            end else if (r_k == '0) begin
              w_state_next = POST;
            end else begin
              w_k_next     = r_k - KW'(1);
              w_state_next = SQUARE;
            end
          end
          POST: begin
            w_c_next     = w_mp_u;
            w_state_next = DONE;
          end
          default: ;
        endcase
      end
    end
  end

  // State, datapath registers and job operand latch.
  always_ff @(posedge clk or negedge rstn) begin
    if (!rstn) begin
      r_state <= IDLE;
      r_busy  <= 1'b0;
      r_k     <= '0;
      r_x     <= '0;
      r_mbar  <= '0;
      r_c     <= '0;
      r_m     <= '0;
      r_e     <= '0;
      r_n     <= '0;
      r_r2    <= '0;
    end else begin
      r_state <= w_state_next;
      r_busy  <= w_busy_next;
      r_k     <= w_k_next;
      r_x     <= w_x_next;
      r_mbar  <= w_mbar_next;
      r_c     <= w_c_next;
      if (w_accept) begin
        r_m  <= bus.i_M;
        r_e  <= bus.i_E;
        r_n  <= bus.i_N;
        r_r2 <= bus.i_R2;
      end
    end
  end

  modexp_monpro #(.DATAWIDTH(DATAWIDTH)) u_monpro (
    .clk     (clk),
    .rstn    (rstn),
    .i_start (w_mp_start),
    .i_A     (w_mp_a),
    .i_B     (w_mp_b),
    .i_N     (r_n),
    .o_ready (w_mp_ready),
    .o_valid (w_mp_valid),
    .o_U     (w_mp_u)
  );

  assign bus.i_ready = (r_state == IDLE);
  assign bus.o_valid = (r_state == DONE);
  assign bus.o_C     = r_c;

endmodule

// File: tb/tb_modexp.sv
// Scoreboard bench for modexp at DATAWIDTH=8: directed vectors, backpressure,
// mid-job reset and randomized jobs against a plain-arithmetic model.
module tb_modexp;
  import modexp_pkg::*;

  localparam int W = 8;

  logic clk  = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  modexp_if #(.DATAWIDTH(W)) bus ();

  modexp #(.DATAWIDTH(W)) dut (
    .clk  (clk),
    .rstn (rstn),
    .bus  (bus.slave)
  );

  int n_checks = 0;
  int n_fail   = 0;
  int start_cnt = 0;
  logic [W-1:0] exp_q[$];

  // Counts multiplier start pulses seen inside the DUT.
  always @(negedge clk) if (rstn && dut.w_mp_start) start_cnt++;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] expv);
    n_checks++;
    if (act !== expv) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, expv);
    end else begin
      $display("ok   %s: 0x%0h", name, act);
    end
  endtask

  // Reference: repeated multiplication modulo N.
  function automatic logic [W-1:0] ref_modexp(input int unsigned m, input int unsigned e,
                                               input int unsigned n);
    longint unsigned r;
    r = 1 % n;
    for (int i = 0; i < e; i++) r = (r * m) % n;
    return r[W-1:0];
  endfunction

  // Monitor: compares every consumed result with the scoreboard head.
  always @(negedge clk) begin : monitor
    logic [W-1:0] e_val;
    if (rstn && bus.o_valid && bus.o_ready) begin
      if (exp_q.size() == 0) begin
        n_checks++;
        n_fail++;
        $display("FAIL unexpected_result: got 0x%0h expected none", bus.o_C);
      end else begin
        e_val = exp_q.pop_front();
        check("result", {24'd0, bus.o_C}, {24'd0, e_val});
      end
    end
  end

  task automatic issue(input logic [W-1:0] m, input logic [W-1:0] e,
                       input logic [W-1:0] n, input logic [W-1:0] r2);
    int cyc;
    cyc = 0;
    @(posedge clk); #2;
    while (!bus.i_ready && cyc < 2000) begin
      @(posedge clk); #2;
      cyc++;
    end
    if (!bus.i_ready) begin
      n_checks++;
      n_fail++;
      $display("FAIL ready_timeout: got i_ready=0 expected 1");
    end
    bus.i_valid = 1'b1;
    bus.i_M = m; bus.i_E = e; bus.i_N = n; bus.i_R2 = r2;
    @(posedge clk);
    exp_q.push_back(ref_modexp(m, e, n));
    #2;
    bus.i_valid = 1'b0;
  endtask

  task automatic wait_done();
    int cyc;
    cyc = 0;
    while (exp_q.size() != 0 && cyc < 5000) begin
      @(negedge clk);
      cyc++;
    end
    if (exp_q.size() != 0) begin
      n_checks++;
      n_fail++;
      $display("FAIL result_timeout: got %0d pending expected 0", exp_q.size());
      exp_q.delete();
    end
  endtask

  task automatic run_job(input logic [W-1:0] m, input logic [W-1:0] e,
                         input logic [W-1:0] n, input logic [W-1:0] r2);
    int s0;
    s0 = start_cnt;
    issue(m, e, n, r2);
    wait_done();
    check("monpro_ops", start_cnt - s0, 3 + W + $countones(e));
  endtask

  initial begin : watchdog
    #5_000_000;
    $display("FAIL watchdog: got no finish expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin : stim
    logic [W-1:0] n, m, e, r2, c_exp;
    int cyc;
    bus.i_valid = 1'b0;
    bus.i_M = '0; bus.i_E = '0; bus.i_N = '0; bus.i_R2 = '0;
    bus.o_ready = 1'b1;

    // Reset state
    repeat (3) @(posedge clk);
    #2;
    check("rst_i_ready", {31'd0, bus.i_ready}, 32'd1);
    check("rst_o_valid", {31'd0, bus.o_valid}, 32'd0);
    check("rst_o_C", {24'd0, bus.o_C}, 32'd0);
    rstn = 1'b1;

    // Directed vectors
    run_job(8'h05, 8'h03, 8'h77, 8'h56);
    run_job(8'h10, 8'h00, 8'h77, 8'h56);
    run_job(8'h10, 8'h01, 8'h77, 8'h56);
    run_job(8'h00, 8'h05, 8'h77, 8'h56);
    run_job(8'h76, 8'hFF, 8'h77, 8'h56);

    // Backpressure: result held, inputs ignored while busy and in DONE
    bus.o_ready = 1'b0;
    issue(8'h05, 8'h03, 8'h77, 8'h56);
    c_exp = ref_modexp(5, 3, 8'h77);
    bus.i_valid = 1'b1;
    bus.i_M = 8'h07; bus.i_E = 8'h09; bus.i_N = 8'h77; bus.i_R2 = 8'h56;
    cyc = 0;
    while (!bus.o_valid && cyc < 2000) begin
      @(posedge clk); #2;
      cyc++;
    end
    check("bp_o_valid_seen", {31'd0, bus.o_valid}, 32'd1);
    for (int i = 0; i < 20; i++) begin
      @(posedge clk); #2;
      check("bp_hold_valid", {31'd0, bus.o_valid}, 32'd1);
      check("bp_hold_C", {24'd0, bus.o_C}, {24'd0, c_exp});
      check("bp_i_ready_low", {31'd0, bus.i_ready}, 32'd0);
    end
    bus.i_valid = 1'b0;
    bus.o_ready = 1'b1;
    wait_done();
    @(posedge clk); #2;
    check("bp_o_valid_drop", {31'd0, bus.o_valid}, 32'd0);
    check("bp_i_ready_back", {31'd0, bus.i_ready}, 32'd1);

    // Mid-job reset during SQUARE aborts without a result
    issue(8'h05, 8'h03, 8'h77, 8'h56);
    cyc = 0;
    while (dut.r_state != SQUARE && cyc < 2000) begin
      @(posedge clk); #2;
      cyc++;
    end
    check("rst_reached_square", {31'd0, dut.r_state == SQUARE}, 32'd1);
    rstn = 1'b0;
    exp_q.delete();
    #1;
    check("midrst_o_valid", {31'd0, bus.o_valid}, 32'd0);
    check("midrst_i_ready", {31'd0, bus.i_ready}, 32'd1);
    @(posedge clk); #2;
    rstn = 1'b1;
    @(posedge clk); #2;
    check("postrst_i_ready", {31'd0, bus.i_ready}, 32'd1);
    repeat (30) @(posedge clk);
    #2;
    check("postrst_o_valid", {31'd0, bus.o_valid}, 32'd0);
    run_job(8'h05, 8'h03, 8'h77, 8'h56);

    // Randomized jobs: odd N with MSB set, M < N
    for (int j = 0; j < 40; j++) begin
      n  = W'($urandom_range(64, 127) * 2 + 1);
      m  = W'($urandom_range(0, int'(n) - 1));
      e  = W'($urandom_range(0, 255));
      r2 = W'((256 * 256) % int'(n));
      run_job(m, e, n, r2);
    end

    repeat (5) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
